programmable_seq_counter: RTL
=============================

// Module: programmable_seq_counter
// PURPOSE
// Parametrised successor to the fixed-sequence counter: steps through a run-time programmable
// table of WIDTH-bit codes instead of a hard-wired sequence. Supports forward/reverse stepping,
// wrap, bounce (ping-pong), one-shot and hold modes, plus programmable sequence length.
// Sits beside pattern/LED/stepper drivers as a generic sequence source.
// PARAMETERS
// WIDTH   4  bit width of each sequence code and of counter
// DEPTH   8  max table entries (power of 2, >=2)
// ADDR_W  3  index width, = log2(DEPTH)
// PORTS
// clk       in   1       single clock, all logic on rising edge
// reset     in   1       synchronous, active-high
// en        in   1       advance one step this cycle
// dir       in   1       0 = forward (index+1), 1 = reverse (index-1); ignored in BOUNCE after start
// mode      in   2       00 WRAP, 01 BOUNCE, 10 ONESHOT, 11 HOLD
// restart   in   1       return to start entry, clear done
// last_idx  in   ADDR_W  index of last valid entry (sequence length = last_idx+1)
// wr_en     in   1       write table entry
// wr_addr   in   ADDR_W  table entry to write
// wr_data   in   WIDTH   code to write
// counter   out  WIDTH   current code = table[index], registered
// index     out  ADDR_W  current table index, registered
// wrap      out  1       1-cycle pulse on the step that wraps or reverses at an end
// done      out  1       ONESHOT end reached; held until restart/reset
// BEHAVIOUR
// - Reset: table[i] = i (mod 2^WIDTH); index=0; counter=0; wrap=0; done=0; bounce dir=forward.
// - Priority per cycle: reset > restart > step (en). Table write is independent of all three.
// - restart: index = 0 if dir=0 else last_idx; counter = that entry; done=0; wrap=0;
//   bounce direction loads from dir.
// - Step (en=1, mode!=HOLD, done=0): next index per mode; counter loads table[next]; 1-cycle latency.
//   WRAP fwd: last_idx -> 0 with wrap=1; rev: 0 -> last_idx with wrap=1.
//   BOUNCE: internal direction flips at 0 or last_idx; step moves off the end (…,L-1,L,L-1,…);
//     wrap=1 on the step that flips. last_idx=0: index stays 0, wrap=1 each step.
//   ONESHOT: advances toward end; step arriving at end (last_idx fwd / 0 rev) sets done=1;
//     further steps ignored until restart. wrap stays 0.
//   HOLD: index/counter frozen, en ignored; done unchanged.
// - en=0: all state held; wrap=0.
// - last_idx changed so index > last_idx: next step (any dir) goes to 0 (fwd) or last_idx (rev),
//   wrap=1. No action without a step.
// - Write/read collision: step whose next index == wr_addr with wr_en=1 loads wr_data into counter
//   (write-first). Writing the currently displayed entry without a step does not change counter.
// - mode change takes effect on the next step; BOUNCE internal direction loads from dir when
//   entering BOUNCE from another mode.
// - Reset mid-sequence restores default table contents (programmed codes lost).
// - Index arithmetic modulo DEPTH, then clamped per last_idx rules above; no X on any output.
// TESTING
// (clk period 10 ns, reset high first 10 ns)
// 1 Reset default, WRAP fwd, last_idx=7, en=1 -> counter 0,1,..,7,0; wrap pulse on 7->0 step.
// 2 Program table {0,1,3,7,15,14,12,8}, last_idx=7, dir=1 -> 0,8,12,14,15,7,3,1,0; wrap on 0->8.
// 3 BOUNCE, last_idx=3, dir=0 -> index 0,1,2,3,2,1,0,1; wrap on 3->2 and 0->1 steps.
// 4 ONESHOT, last_idx=4 -> index 0..4, done=1 at 4, en continues, stays 4; restart -> 0, done=0.
// 5 en toggling + HOLD mode mid-run -> index frozen; last_idx 7->2 while index=5, step -> 0, wrap=1.
// 6 wr_en to next index same cycle as step, wr_data=4'hA -> counter=A next cycle; reset mid-run
//   -> counter=0, index=0, table back to identity.

Source files
------------

// File: rtl/programmable_seq_counter_if.sv
// Control, table-write and status signals of the programmable sequence counter.
// The master drives the controls; the slave (the counter) drives the status outputs.
interface programmable_seq_counter_if #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 3
);
    logic              en;
    logic              dir;
    logic [1:0]        mode;
    logic              restart;
    logic [ADDR_W-1:0] last_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  counter;
    logic [ADDR_W-1:0] index;
    logic              wrap;
    logic              done;

    modport master (
        output en, dir, mode, restart, last_idx, wr_en, wr_addr, wr_data,
        input  counter, index, wrap, done
    );

    modport slave (
        input  en, dir, mode, restart, last_idx, wr_en, wr_addr, wr_data,
        output counter, index, wrap, done
    );
endinterface

// File: rtl/programmable_seq_counter.sv
// Steps through a run-time programmable table of codes in wrap, bounce, one-shot or hold mode.
// The table is a register array so that reset can restore its identity contents.
module programmable_seq_counter #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input logic                         clk,
    input logic                         reset,
    programmable_seq_counter_if.slave   bus
);
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_BOUNCE  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  counter_q, counter_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              bdir_q, bdir_d;
    logic              in_bounce_q;

    mode_e             mode;
    logic              down;
    logic              step_go;
    logic              load;
    logic [ADDR_W-1:0] end_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset)
                    mem_q[gi] <= WIDTH'(gi);
                else if (bus.wr_en && bus.wr_addr == ADDR_W'(gi))
                    mem_q[gi] <= bus.wr_data;
            end
        end
    endgenerate

    // Bounce direction comes from dir on the first cycle spent in BOUNCE.
    assign mode    = mode_e'(bus.mode);
    assign down    = (mode == MODE_BOUNCE && in_bounce_q) ? bdir_q : bus.dir;
    assign step_go = bus.en && (mode != MODE_HOLD) && !done_q;
    assign end_idx = down ? '0 : bus.last_idx;

    always_comb begin
        index_d   = index_q;
        wrap_d    = 1'b0;
        done_d    = done_q;
        bdir_d    = bdir_q;
        load      = 1'b0;
        counter_d = counter_q;
        if (mode == MODE_BOUNCE && !in_bounce_q)
            bdir_d = bus.dir;
        if (bus.restart) begin
            index_d = bus.dir ? bus.last_idx : '0;
            done_d  = 1'b0;
            bdir_d  = bus.dir;
            load    = 1'b1;
        end else if (step_go) begin
            load = 1'b1;
            if (index_q > bus.last_idx) begin
                index_d = down ? bus.last_idx : '0;
                wrap_d  = 1'b1;
                if (mode == MODE_ONESHOT && index_d == end_idx)
                    done_d = 1'b1;
            end else begin
                unique case (mode)
                    MODE_WRAP: begin
                        if (index_q == end_idx) begin
                            index_d = down ? bus.last_idx : '0;
                            wrap_d  = 1'b1;
                        end else begin
                            index_d = down ? index_q - ADDR_W'(1) : index_q + ADDR_W'(1);
                        end
                    end
                    MODE_BOUNCE: begin
                        if (bus.last_idx == '0) begin
                            index_d = '0;
                            wrap_d  = 1'b1;
                        end else if (index_q == end_idx) begin
                            index_d = down ? index_q + ADDR_W'(1) : index_q - ADDR_W'(1);
                            bdir_d  = !down;
                            wrap_d  = 1'b1;
                        end else begin
                            index_d = down ? index_q - ADDR_W'(1) : index_q + ADDR_W'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (index_q != end_idx)
                            index_d = down ? index_q - ADDR_W'(1) : index_q + ADDR_W'(1);
                        done_d = (index_d == end_idx);
                    end
                    default: ;
                endcase
            end
        end
        // Write-first: a same-cycle write to the destination entry wins over the stored code.
        if (load)
            counter_d = (bus.wr_en && bus.wr_addr == index_d) ? bus.wr_data : mem_q[index_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q   <= '0;
            index_q     <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            bdir_q      <= 1'b0;
            in_bounce_q <= 1'b1;
        end else begin
            counter_q   <= counter_d;
            index_q     <= index_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            bdir_q      <= bdir_d;
            in_bounce_q <= (mode == MODE_BOUNCE);
        end
    end

    assign bus.counter = counter_q;
    assign bus.index   = index_q;
    assign bus.wrap    = wrap_q;
    assign bus.done    = done_q;
endmodule
